i2s_master_tx: RTL and testbench
================================

# i2s_master_tx

Standalone I2S bus-master transmitter for the MusicSampler audio path. The FPGA generates the serial clock (`sclk`) and word clock (`lrclk`) itself from the 50 MHz system clock, rather than taking them from the codec. Stereo samples arrive through a valid/ready interface into a small FIFO and are serialized MSB-first in standard Philips I2S format, with a one-bit delay after each `lrclk` edge. The block drives the codec DAC pins, and its clocks can be fanned out to the existing I2S slave-side receiver logic.

## Interface
- `CLK_DIV`, 8: `sclk` half-period in `clk` cycles. Must be ≥2. Default gives 3.125 MHz `sclk` and fs ≈ 48.83 kHz.
- `SAMPLE_W`, 24: sample width. Must be ≤ `SLOT_W`−1.
- `SLOT_W`, 32: `sclk` cycles per channel slot.
- `FIFO_DEPTH`, 4: sample-pair FIFO entries. Must be a power of 2.

Ports:
- `clk` in 1: system clock (MAX10_CLK1_50).
- `Reset_h` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a sample pair is offered.
- `in_ready` out 1: the FIFO can accept a pair.
- `in_l` in `SAMPLE_W`: left sample, two's complement.
- `in_r` in `SAMPLE_W`: right sample, two's complement.
- `clr_underrun` in 1: clears `underrun`.
- `sclk` out 1: I2S bit clock.
- `lrclk` out 1: word select. 0 = left, 1 = right.
- `d_out` out 1: serial data.
- `underrun` out 1: sticky flag; a frame started with the FIFO empty.
- `fifo_level` out `$clog2(FIFO_DEPTH+1)`: number of occupied entries.

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_DIV`−1. When it reaches terminal count, `sclk` toggles and `div_cnt` returns to 0.
- **Bit counter.** On each `sclk` falling edge (the clk cycle where `sclk` goes 1→0), `bit_idx` advances modulo 2·`SLOT_W`.
- **Word clock.** `lrclk` = 0 for `bit_idx` 0..`SLOT_W`−1 and 1 for `SLOT_W`..2·`SLOT_W`−1.
- **Left slot data.** At `bit_idx` 0, `d_out` = 0. For `bit_idx` 1..`SAMPLE_W`, `d_out` carries L MSB-first. The rest of the slot is 0.
- **Right slot data.** The same pattern, offset by `SLOT_W`: `bit_idx` `SLOT_W` carries 0, the next `SAMPLE_W` bits carry R MSB-first, the rest is 0.
- **Data edge.** `d_out` and `lrclk` change only on `sclk` falling edges. The receiver samples on rising edges.
- **Frame load.** On the falling edge where `bit_idx` wraps to 0:
  - If the FIFO is non-empty, pop the head pair into the frame shift register.
  - If the FIFO is empty, load zeros, set `underrun`, and do not pop.
- **FIFO push.** A push occurs when `in_valid` && `in_ready`.
- **`in_ready`.** `in_ready` = (count < `FIFO_DEPTH`). It is a function of registered count only; there is no combinational path from a pop in the same cycle.
- **Simultaneous push and pop.** Count is unchanged.
- **Flag priority.** If `clr_underrun` coincides with a new underrun, set wins.
- **Arithmetic.** Samples are passed through bit-exact; there is no truncation or sign extension.

## Timing
- **Reset values** (asynchronous): `sclk`=0, `lrclk`=1, `d_out`=0, `bit_idx`=2·`SLOT_W`−1, `div_cnt`=0, FIFO empty, `in_ready`=1, `fifo_level`=0, `underrun`=0.
- **First edges after reset release:**
  - First `sclk` rise at clk cycle `CLK_DIV`.
  - First fall at cycle 2·`CLK_DIV`. At that fall, `bit_idx`→0, `lrclk`→0, and the first frame loads.
- **Periods.** `sclk` period = 2·`CLK_DIV` clk. Frame = 4·`SLOT_W`·`CLK_DIV` clk (1024 at defaults).
- **Registered outputs.** All outputs are registered.
- **FIFO latency.** `fifo_level` updates one cycle after the push/pop edge.
- **Push visibility.** A push accepted in the same cycle as a frame load is not visible to that load. It transmits in the next frame.
- **Output latency.** The L MSB appears on `d_out` one `sclk` period after the frame-load fall.
- **Mid-operation reset.** Reset mid-frame aborts the frame immediately, flushes the FIFO, and returns all outputs to their reset values.

## Structure
- **Package `i2s_pkg`:**
  - `SLOT_W` default constant.
  - `typedef struct packed {logic [SAMPLE_W-1:0] l, r;} sample_pair_t`.
  - Frame-length constant 2·`SLOT_W`.
- **Sub-module `sample_fifo`:** synchronous FIFO with parameterized width and depth, pointer wrap, count, and full/empty signals.
- **Top-level logic:** the divider, bit counter, shift register, and underrun flag stay in `i2s_master_tx`.

## Test plan
- **Reset values:** hold `Reset_h` 5 cycles, release → all outputs at their reset values; first `sclk` rise at cycle 8; first fall at cycle 16 with `lrclk`=0.
- **Bit-exact frame:** push L=24'hABCDEF, R=24'h123456 before the first fall → sampled on `sclk` rises, the left slot reads 0,ABCDEF,7'b0 and the right slot reads 0,123456,7'b0; `underrun` stays 0.
- **Underrun:** no push → frame of all zeros and `underrun`=1. Assert `clr_underrun` → 0. Assert `clr_underrun` on the next empty frame load → stays 1.
- **Backpressure:** push 5 pairs back-to-back with `in_valid` held → 4 accepted, `in_ready`=0, `fifo_level`=4. After the next frame load, `in_ready` returns to 1 and the 5th pair is accepted.
- **Push/pop overlap:** push exactly on a frame-load cycle with `fifo_level`=1 → level stays 1; the old pair transmits now and the new pair transmits next frame.
- **Mid-frame reset:** assert `Reset_h` at `bit_idx`=40 → immediate reset values and FIFO flushed; the timeline after release matches the first scenario.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and sample-pair type for the I2S master transmitter
package i2s_pkg;

    localparam int I2S_SLOT_W    = 32;
    localparam int I2S_SAMPLE_W  = 24;
    localparam int I2S_FRAME_LEN = 2 * I2S_SLOT_W;

    typedef struct packed {
        logic [I2S_SAMPLE_W-1:0] l;
        logic [I2S_SAMPLE_W-1:0] r;
    } sample_pair_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO with occupancy count, full and empty
module sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S bus master: generates sclk/lrclk and serializes stereo samples MSB-first
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int SAMPLE_W   = I2S_SAMPLE_W,
    parameter int SLOT_W     = I2S_SLOT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            Reset_h,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SAMPLE_W-1:0]             in_l,
    input  logic [SAMPLE_W-1:0]             in_r,
    input  logic                            clr_underrun,
    output logic                            sclk,
    output logic                            lrclk,
    output logic                            d_out,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int IDX_W = $clog2(FRAME);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PAIR_W = 2 * SAMPLE_W;

    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME - 1);
    localparam logic [IDX_W-1:0] R_START  = IDX_W'(SLOT_W);
    localparam logic [IDX_W-1:0] L_FIRST  = IDX_W'(1);
    localparam logic [IDX_W-1:0] L_LAST   = IDX_W'(SAMPLE_W);
    localparam logic [IDX_W-1:0] R_FIRST  = IDX_W'(SLOT_W + 1);
    localparam logic [IDX_W-1:0] R_LAST   = IDX_W'(SLOT_W + SAMPLE_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [PAIR_W-1:0] shreg;
    logic [PAIR_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              sclk_tc;
    logic              sclk_fall;
    logic              frame_load;
    logic              data_bit;

    assign sclk_tc    = (div_cnt == DIV_TC);
    assign sclk_fall  = sclk_tc && sclk;
    assign next_idx   = (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
    assign frame_load = sclk_fall && (next_idx == '0);
    assign data_bit   = ((next_idx >= L_FIRST) && (next_idx <= L_LAST)) ||
                        ((next_idx >= R_FIRST) && (next_idx <= R_LAST));
    assign in_ready   = !fifo_full;

    // Pop is driven from registered FIFO state only, so a push on the load edge waits a frame.
    sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (Reset_h),
        .push  (in_valid && in_ready),
        .wdata ({in_l, in_r}),
        .pop   (frame_load),
        .rdata (fifo_rdata),
        .count (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge Reset_h) begin
        if (Reset_h) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            bit_idx  <= LAST_IDX;
            lrclk    <= 1'b1;
            d_out    <= 1'b0;
            shreg    <= '0;
            underrun <= 1'b0;
        end else begin
            div_cnt <= sclk_tc ? '0 : div_cnt + 1'b1;
            if (sclk_tc) begin
                sclk <= ~sclk;
            end
            // Left sample sits in the upper half, so after its shifts the right sample is at the MSB.
            if (sclk_fall) begin
                bit_idx <= next_idx;
                lrclk   <= (next_idx >= R_START);
                if (frame_load) begin
                    shreg <= fifo_empty ? '0 : fifo_rdata;
                    d_out <= 1'b0;
                end else if (data_bit) begin
                    d_out <= shreg[PAIR_W-1];
                    shreg <= {shreg[PAIR_W-2:0], 1'b0};
                end else begin
                    d_out <= 1'b0;
                end
            end
            if (frame_load && fifo_empty) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb/tb_i2s_master_tx.sv - directed, table-driven bench for i2s_master_tx
module tb_i2s_master_tx;
    import i2s_pkg::*;

    logic                    clk = 1'b0;
    logic                    Reset_h = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [I2S_SAMPLE_W-1:0] in_l = '0;
    logic [I2S_SAMPLE_W-1:0] in_r = '0;
    logic                    clr_underrun = 1'b0;
    logic                    sclk;
    logic                    lrclk;
    logic                    d_out;
    logic                    underrun;
    logic [2:0]              fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       sclk;
        logic       lrclk;
        logic       d_out;
        logic       in_ready;
        logic [2:0] level;
        logic       underrun;
    } vec_t;

    vec_t         vecs [6];
    sample_pair_t pairs [5];
    sample_pair_t pq;
    sample_pair_t pz;
    logic [63:0]  w;

    i2s_master_tx #(
        .CLK_DIV    (8),
        .SAMPLE_W   (24),
        .SLOT_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .Reset_h      (Reset_h),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_l         (in_l),
        .in_r         (in_r),
        .clr_underrun (clr_underrun),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .d_out        (d_out),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        Reset_h = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        Reset_h = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    task automatic capture(input int load, output logic [63:0] word);
        word = '0;
        for (int n = 0; n < 64; n++) begin
            goto(load + 8 + 16 * n);
            word[63-n] = d_out;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_sclk"}, 64'(sclk), 64'd0);
        chk({tag, "_lrclk"}, 64'(lrclk), 64'd1);
        chk({tag, "_d_out"}, 64'(d_out), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_level"}, 64'(fifo_level), 64'd0);
        chk({tag, "_underrun"}, 64'(underrun), 64'd0);
    endtask

    task automatic run_boot();
        check_reset_state("rst");
        in_valid = 1'b1;
        in_l = 24'hABCDEF;
        in_r = 24'h123456;
        goto(1);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            goto(vecs[i].cyc);
            chk("tl_sclk", 64'(sclk), 64'(vecs[i].sclk));
            chk("tl_lrclk", 64'(lrclk), 64'(vecs[i].lrclk));
            chk("tl_d_out", 64'(d_out), 64'(vecs[i].d_out));
            chk("tl_in_ready", 64'(in_ready), 64'(vecs[i].in_ready));
            chk("tl_level", 64'(fifo_level), 64'(vecs[i].level));
            chk("tl_underrun", 64'(underrun), 64'(vecs[i].underrun));
        end
        capture(16, w);
        chk("frame0", w, exp_frame(24'hABCDEF, 24'h123456));
        goto(1032);
        chk("frame0_underrun", 64'(underrun), 64'd0);
    endtask

    initial begin
        vecs[0] = '{cyc: 1,  sclk: 0, lrclk: 1, d_out: 0, in_ready: 1, level: 3'd1, underrun: 0};
        vecs[1] = '{cyc: 7,  sclk: 0, lrclk: 1, d_out: 0, in_ready: 1, level: 3'd1, underrun: 0};
        vecs[2] = '{cyc: 8,  sclk: 1, lrclk: 1, d_out: 0, in_ready: 1, level: 3'd1, underrun: 0};
        vecs[3] = '{cyc: 15, sclk: 1, lrclk: 1, d_out: 0, in_ready: 1, level: 3'd1, underrun: 0};
        vecs[4] = '{cyc: 16, sclk: 0, lrclk: 0, d_out: 0, in_ready: 1, level: 3'd0, underrun: 0};
        vecs[5] = '{cyc: 24, sclk: 1, lrclk: 0, d_out: 0, in_ready: 1, level: 3'd0, underrun: 0};

        pairs[0].l = 24'h800001; pairs[0].r = 24'h7FFFFE;
        pairs[1].l = 24'hFFFFFF; pairs[1].r = 24'h000000;
        pairs[2].l = 24'h000001; pairs[2].r = 24'h800000;
        pairs[3].l = 24'h5A5A5A; pairs[3].r = 24'hA5A5A5;
        pairs[4].l = 24'h00F00F; pairs[4].r = 24'hF00F00;
        pq.l = 24'h13579B; pq.r = 24'h2468AC;
        pz.l = 24'hDEAD00; pz.r = 24'hBEEF00;

        do_reset();
        run_boot();

        // Empty FIFO at the next load: zero frame and sticky underrun.
        goto(1040);
        chk("underrun_set", 64'(underrun), 64'd1);
        capture(1040, w);
        chk("frame1_zero", w, 64'd0);
        chk("underrun_sticky", 64'(underrun), 64'd1);
        clr_underrun = 1'b1;
        goto(2057);
        clr_underrun = 1'b0;
        chk("underrun_clear", 64'(underrun), 64'd0);
        goto(2063);
        clr_underrun = 1'b1;
        goto(2064);
        clr_underrun = 1'b0;
        chk("underrun_set_wins", 64'(underrun), 64'd1);

        // Backpressure: five back-to-back offers, four fit.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_l = pairs[i].l;
            in_r = pairs[i].r;
            goto(2065 + i);
        end
        in_l = pairs[4].l;
        in_r = pairs[4].r;
        goto(2069);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_level_full", 64'(fifo_level), 64'd4);
        goto(3088);
        chk("bp_level_after_pop", 64'(fifo_level), 64'd3);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        goto(3089);
        in_valid = 1'b0;
        chk("bp_fifth_accepted", 64'(fifo_level), 64'd4);
        capture(3088, w);
        chk("frame3_p0", w, exp_frame(pairs[0].l, pairs[0].r));
        capture(4112, w);
        chk("frame4_p1", w, exp_frame(pairs[1].l, pairs[1].r));

        // Push on the load edge with one entry queued.
        goto(7183);
        chk("ovl_level_before", 64'(fifo_level), 64'd1);
        in_valid = 1'b1;
        in_l = pq.l;
        in_r = pq.r;
        goto(7184);
        in_valid = 1'b0;
        chk("ovl_level_same", 64'(fifo_level), 64'd1);
        capture(7184, w);
        chk("frame7_old_pair", w, exp_frame(pairs[4].l, pairs[4].r));
        capture(8208, w);
        chk("frame8_new_pair", w, exp_frame(pq.l, pq.r));

        // Mid-frame reset with a pair queued and underrun set.
        goto(9299);
        in_valid = 1'b1;
        in_l = pz.l;
        in_r = pz.r;
        goto(9300);
        in_valid = 1'b0;
        chk("pre_reset_level", 64'(fifo_level), 64'd1);
        chk("pre_reset_underrun", 64'(underrun), 64'd1);
        goto(9873);
        Reset_h = 1'b1;
        #1;
        check_reset_state("async_rst");
        do_reset();
        run_boot();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
